inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 80 ++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer of
// {pc, instr, adel} entries with a write pointer, a read pointer and an
// occupancy counter. There is no bypass in either direction: a full queue
// refuses input even when it is popping, and an empty queue shows nothing
// until the cycle after a push.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instr,
  output logic                     out_adel,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_pc    [DEPTH];
  logic [WIDTH-1:0] r_instr [DEPTH];
  logic             r_adel  [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_adel;

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  // Reset and flush both discard same-cycle traffic.
  assign w_push    = in_valid && in_ready && !rst && !flush;
  assign w_pop     = out_valid && out_ready && !rst && !flush;
  // Instruction fetch from a non-word-aligned PC is an address error.
  assign w_adel    = (in_pc[1:0] != 2'b00);

  // Head entry is presented only while valid; zeroed otherwise.
  assign out_pc    = out_valid ? r_pc[r_rptr]    : '0;
  assign out_instr = out_valid ? r_instr[r_rptr] : '0;
  assign out_adel  = out_valid ? r_adel[r_rptr]  : 1'b0;
  assign count     = r_count;

  // Entry storage: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wptr]    <= in_pc;
      r_instr[r_wptr] <= in_instr;
      r_adel[r_wptr]  <= w_adel;
    end
  end

  // Pointers and occupancy; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
